// File: rtl/pushbtn_poller_pkg.sv
// rtl/pushbtn_poller_pkg.sv - shared push-button instruction codes and poller state encoding
package pushbtn_poller_pkg;

    localparam logic [3:0] INST_NOP = 4'h0;
    localparam logic [3:0] INST_RBS = 4'h1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    function automatic logic [11:0] make_inst(input logic [3:0] code);
        return {code, 8'h00};
    endfunction

endpackage

// File: rtl/pushbtn_poll_timer.sv
// rtl/pushbtn_poll_timer.sv - reloadable down-counter that holds at zero
module pushbtn_poll_timer #(
    parameter int Width = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic [Width-1:0] count,
    output logic             zero
);

    localparam logic [Width-1:0] One = Width'(1);

    logic [Width-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - One;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pushbtn_poller.sv
// rtl/pushbtn_poller.sv - periodically issues RBS to the push-button peripheral and counts presses
module pushbtn_poller
    import pushbtn_poller_pkg::*;
#(
    parameter int PollPeriod = 40000,
    parameter int PollSize   = 16,
    parameter int CountSize  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 poll_enable,
    input  logic                 clear,
    output logic [11:0]          inst,
    output logic                 inst_en,
    input  logic                 button_status,
    output logic                 press_pulse,
    output logic [CountSize-1:0] press_count,
    output logic                 error
);

    localparam logic [PollSize-1:0]  Reload   = PollSize'(PollPeriod - 1);
    localparam logic [CountSize-1:0] CountMax = '1;
    localparam logic [CountSize-1:0] CountOne = CountSize'(1);

    state_e                 state_q, state_d;
    logic                   pulse_q, pulse_d;
    logic [CountSize-1:0]   count_q, count_d;
    logic                   timer_load;
    logic                   timer_zero;
    logic [PollSize-1:0]    timer_count_unused;
    logic                   hit;

    pushbtn_poll_timer #(
        .Width (PollSize)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .value (Reload),
        .count (timer_count_unused),
        .zero  (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RESET;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_load = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d    = ST_WAIT;
                timer_load = 1'b1;
            end
            ST_WAIT: begin
                if (timer_zero && poll_enable) state_d = ST_ISSUE;
            end
            ST_ISSUE:  state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                state_d    = ST_WAIT;
                timer_load = 1'b1;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
    end

    // A clear in the same cycle as a detected press leaves exactly that press counted.
    always_comb begin
        hit     = (state_q == ST_SAMPLE) && button_status;
        pulse_d = hit;
        count_d = count_q;
        if (clear) begin
            count_d = hit ? CountOne : '0;
        end else if (hit && (count_q != CountMax)) begin
            count_d = count_q + CountOne;
        end
    end

    assign inst        = (state_q == ST_ISSUE) ? make_inst(INST_RBS) : make_inst(INST_NOP);
    assign inst_en     = (state_q == ST_ISSUE);
    assign press_pulse = pulse_q && (state_q != ST_ERROR);
    assign press_count = count_q;
    assign error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_pushbtn_poller.sv
// tb/tb_pushbtn_poller.sv - directed self-checking bench for pushbtn_poller
module tb_pushbtn_poller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        poll_enable = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] inst;
    logic        inst_en;
    logic        button_status = 1'b0;
    logic        press_pulse;
    logic [1:0]  press_count;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pushbtn_poller #(
        .PollPeriod (4),
        .PollSize   (16),
        .CountSize  (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .poll_enable   (poll_enable),
        .clear         (clear),
        .inst          (inst),
        .inst_en       (inst_en),
        .button_status (button_status),
        .press_pulse   (press_pulse),
        .press_count   (press_count),
        .error         (error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input logic pe);
        reset = 1'b1;
        clear = 1'b0;
        button_status = 1'b0;
        poll_enable = pe;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++;
        if (inst !== 12'h000 || inst_en !== 1'b0 || press_pulse !== 1'b0 ||
            press_count !== 2'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst=%h inst_en=%b pulse=%b count=%0d error=%b (want 000 0 0 0 0)",
                     inst, inst_en, press_pulse, press_count, error);
        end
    endtask

    task automatic test_idle_polls();
        logic       exp_en;
        logic [11:0] exp_inst;
        apply_reset(1'b1);
        while (cyc <= 18) begin
            exp_en   = (cyc == 5 || cyc == 11 || cyc == 17);
            exp_inst = exp_en ? 12'h100 : 12'h000;
            checks++;
            if (inst_en !== exp_en || inst !== exp_inst || press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL idle_poll cycle %0d inst_en=%b inst=%h pulse=%b (want %b %h 0)",
                         cyc, inst_en, inst, press_pulse, exp_en, exp_inst);
            end
            step();
        end
    endtask

    task automatic test_single_press();
        apply_reset(1'b1);
        while (cyc <= 12) begin
            button_status = (cyc == 6);
            checks++;
            if (press_pulse !== (cyc == 7)) begin
                errors++;
                $display("FAIL single_press_pulse cycle %0d pulse=%b want %b", cyc, press_pulse, (cyc == 7));
            end
            step();
        end
        button_status = 1'b0;
        checks++;
        if (press_count !== 2'd1) begin
            errors++;
            $display("FAIL single_press_count got %0d want 1", press_count);
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        int k = 0;
        logic [1:0] exp_counts [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        apply_reset(1'b1);
        button_status = 1'b1;
        while (cyc <= 31) begin
            if (press_pulse === 1'b1) pulses++;
            if (cyc == 7 || cyc == 13 || cyc == 19 || cyc == 25 || cyc == 31) begin
                checks++;
                if (press_pulse !== 1'b1 || press_count !== exp_counts[k]) begin
                    errors++;
                    $display("FAIL saturate cycle %0d pulse=%b count=%0d want 1 %0d",
                             cyc, press_pulse, press_count, exp_counts[k]);
                end
                k++;
            end
            step();
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL saturate_pulses got %0d want 5", pulses);
        end
    endtask

    // Runs straight on from test_saturate: count is 3, next Sample at cycle 36.
    task automatic test_clear_collide();
        while (cyc < 36) step();
        clear = 1'b1;
        button_status = 1'b1;
        step();
        clear = 1'b0;
        button_status = 1'b0;
        checks++;
        if (press_count !== 2'd1 || press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_collide count=%0d pulse=%b want 1 1", press_count, press_pulse);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (press_count !== 2'd0 || press_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clear_plain count=%0d pulse=%b want 0 0", press_count, press_pulse);
        end
    endtask

    task automatic test_enable_gate();
        int first = -1;
        apply_reset(1'b0);
        while (cyc < 20) begin
            checks++;
            if (inst_en !== 1'b0) begin
                errors++;
                $display("FAIL gate_disabled cycle %0d inst_en=%b want 0", cyc, inst_en);
            end
            step();
        end
        poll_enable = 1'b1;
        while (cyc <= 24 && first < 0) begin
            if (inst_en === 1'b1) first = cyc;
            else step();
        end
        checks++;
        if (first != 20 && first != 21) begin
            errors++;
            $display("FAIL gate_first_issue cycle=%0d want 20 or 21", first);
        end
    endtask

    task automatic test_enable_drop();
        apply_reset(1'b1);
        button_status = 1'b1;
        while (cyc < 5) step();
        poll_enable = 1'b0;
        while (cyc < 7) step();
        button_status = 1'b0;
        checks++;
        if (press_pulse !== 1'b1 || press_count !== 2'd1) begin
            errors++;
            $display("FAIL enable_drop pulse=%b count=%0d want 1 1", press_pulse, press_count);
        end
        while (cyc <= 15) begin
            checks++;
            if (inst_en !== 1'b0) begin
                errors++;
                $display("FAIL enable_drop_idle cycle %0d inst_en=%b want 0", cyc, inst_en);
            end
            step();
        end
        poll_enable = 1'b1;
    endtask

    task automatic test_reset_mid_issue();
        apply_reset(1'b1);
        button_status = 1'b1;
        while (cyc < 5) step();
        checks++;
        if (inst_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue_setup inst_en=%b want 1", inst_en);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        checks++;
        if (inst_en !== 1'b0 || press_count !== 2'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL mid_issue_reset inst_en=%b count=%0d error=%b want 0 0 0",
                     inst_en, press_count, error);
        end
        while (cyc <= 6) begin
            checks++;
            if (inst_en !== (cyc == 5) || press_pulse !== 1'b0 || press_count !== 2'd0 || error !== 1'b0) begin
                errors++;
                $display("FAIL mid_issue_after cycle %0d inst_en=%b pulse=%b count=%0d error=%b",
                         cyc, inst_en, press_pulse, press_count, error);
            end
            step();
        end
        button_status = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_polls();
        test_single_press();
        test_saturate();
        test_clear_collide();
        test_enable_gate();
        test_enable_drop();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
